alu_mul_sequencer: RTL and testbench

Multi-cycle unsigned 16x16->16 multiplier built on the shared combinational ALU using shift-and-add. It drives the ALU's in1/in2/mode while it owns the ALU. Sits beside the ALU in the execute stage and is started by the control unit for MUL instructions. Reports the low 16 bits of the product plus an exact unsigned-overflow flag.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_sequencer_if.sv | 31 +++
 rtl/alu.sv | 29 ++
 rtl/alu_mul_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and multiply sequencer state encoding
// Ports: none (package). Imported by the ALU and every ALU user.
package alu_pkg;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUBST  = 3'd1;
   localparam logic [2:0] ALU_SHIFTR = 3'd2;
   localparam logic [2:0] ALU_SHIFTL = 3'd3;
   localparam logic [2:0] ALU_AND    = 3'd4;
   localparam logic [2:0] ALU_OR     = 3'd5;
   localparam logic [2:0] ALU_NOT    = 3'd6;
   localparam logic [2:0] ALU_XOR    = 3'd7;

   typedef enum logic [2:0] {
      MUL_IDLE = 3'd0,
      MUL_ADD  = 3'd1,
      MUL_SHL  = 3'd2,
      MUL_SHR  = 3'd3,
      MUL_DONE = 3'd4
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - request/result and ALU-borrow bundle of the multiply sequencer
// Signals: start, abort, op_a, op_b (request); result, ovf, done, busy (response);
//          alu_own, alu_in1, alu_in2, alu_mode (to ALU mux); alu_out (from ALU).
// master: control unit plus ALU side; slave: the sequencer.
interface alu_mul_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result;
   logic             ovf;
   logic             done;
   logic             busy;
   logic             alu_own;
   logic [WIDTH-1:0] alu_in1;
   logic [WIDTH-1:0] alu_in2;
   logic [2:0]       alu_mode;
   logic [WIDTH-1:0] alu_out;

   modport master (
      output start, abort, op_a, op_b, alu_out,
      input  result, ovf, done, busy, alu_own, alu_in1, alu_in2, alu_mode
   );

   modport slave (
      input  start, abort, op_a, op_b, alu_out,
      output result, ovf, done, busy, alu_own, alu_in1, alu_in2, alu_mode
   );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational execute-stage ALU
// Ports: i_in1, i_in2 (operands), i_mode (ALU_* opcode), o_out (result).
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_in1,
   input  logic [WIDTH-1:0] i_in2,
   input  logic [2:0]       i_mode,
   output logic [WIDTH-1:0] o_out
);

   always_comb begin
      o_out = '0;
      case (i_mode)
         ALU_ADD:    o_out = i_in1 + i_in2;
         ALU_SUBST:  o_out = i_in1 - i_in2;
         ALU_SHIFTR: o_out = i_in1 >> i_in2;
         ALU_SHIFTL: o_out = i_in1 << i_in2;
         ALU_AND:    o_out = i_in1 & i_in2;
         ALU_OR:     o_out = i_in1 | i_in2;
         ALU_NOT:    o_out = ~i_in1;
         ALU_XOR:    o_out = i_in1 ^ i_in2;
         default:    o_out = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add unsigned multiplier that borrows the shared ALU
// Ports: clk, rst_n (async active-low); bus (alu_mul_sequencer_if.slave):
//        start/abort/op_a/op_b in, result/ovf/done/busy out, alu_own/alu_in1/alu_in2/alu_mode
//        drive the ALU input mux, alu_out returns the ALU result.
// Option: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_mul_sequencer_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   mul_state_t       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_prod;
   logic [WIDTH-1:0] r_result;
   logic [CW-1:0]    r_cnt;
   logic             r_lost;     // a set bit of the multiplicand has been shifted out
   logic             r_ovf_acc;  // overflow of the operation in flight
   logic             r_ovf;      // overflow of the last completed operation

   logic [WIDTH-1:0] w_alu;
   logic             w_last;
   logic             w_exit;
   logic             w_fin;

   assign w_alu  = bus.alu_out;
   assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
   assign w_exit = w_last || (w_alu == '0);
`else
   assign w_exit = w_last;
`endif

   // abort outranks completion, so a DONE cycle with abort neither pulses done nor commits
   assign w_fin = (r_state == MUL_DONE) && !bus.abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= MUL_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_prod    <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_lost    <= 1'b0;
         r_ovf_acc <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (bus.abort && (r_state != MUL_IDLE)) begin
         r_state <= MUL_IDLE;
      end else begin
         case (r_state)
            MUL_IDLE: begin
               if (bus.start) begin
                  r_a       <= bus.op_a;
                  r_b       <= bus.op_b;
                  r_prod    <= '0;
                  r_cnt     <= '0;
                  r_lost    <= 1'b0;
                  r_ovf_acc <= 1'b0;
                  r_state   <= bus.op_b[0] ? MUL_ADD : MUL_SHL;
               end
            end
            MUL_ADD: begin
               r_prod <= w_alu;
               // a wrapped sum, or adding a multiplicand that already lost a bit, overflows
               if ((w_alu < r_prod) || r_lost) begin
                  r_ovf_acc <= 1'b1;
               end
               r_state <= MUL_SHL;
            end
            MUL_SHL: begin
               r_a <= w_alu;
               if (r_a[WIDTH-1]) begin
                  r_lost <= 1'b1;
               end
               r_state <= MUL_SHR;
            end
            MUL_SHR: begin
               r_b <= w_alu;
               if (w_exit) begin
                  r_state <= MUL_DONE;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_state <= w_alu[0] ? MUL_ADD : MUL_SHL;
               end
            end
            MUL_DONE: begin
               r_result <= r_prod;
               r_ovf    <= r_ovf_acc;
               r_state  <= MUL_IDLE;
            end
            default: r_state <= MUL_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.alu_in1  = '0;
      bus.alu_in2  = '0;
      bus.alu_mode = ALU_ADD;
      case (r_state)
         MUL_ADD: begin
            bus.alu_in1 = r_prod;
            bus.alu_in2 = r_a;
         end
         MUL_SHL: begin
            bus.alu_in1  = r_a;
            bus.alu_in2  = WIDTH'(1);
            bus.alu_mode = ALU_SHIFTL;
         end
         MUL_SHR: begin
            bus.alu_in1  = r_b;
            bus.alu_in2  = WIDTH'(1);
            bus.alu_mode = ALU_SHIFTR;
         end
         default: ;
      endcase
   end

   assign bus.busy    = (r_state != MUL_IDLE);
   assign bus.alu_own = bus.busy;
   assign bus.done    = w_fin;
   // bypass makes the new product visible in the done cycle itself
   assign bus.result  = w_fin ? r_prod : r_result;
   assign bus.ovf     = w_fin ? r_ovf_acc : r_ovf;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - scoreboard bench for alu_mul_sequencer with the real ALU
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int WIDTH = 16;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      int          lat;
   } sb_t;

   logic clk;
   logic rst_n;
   logic [WIDTH-1:0] w_in1;
   logic [WIDTH-1:0] w_in2;
   logic [2:0]       w_mode;

   int          n_cmp;
   int          n_err;
   sb_t         sb_q[$];
   logic [15:0] last_res;
   logic        last_ovf;

   alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_mul_sequencer #(.WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ALU input mux: the sequencer owns the ALU only while alu_own is high
   assign w_in1  = bus.alu_own ? bus.alu_in1 : '0;
   assign w_in2  = bus.alu_own ? bus.alu_in2 : '0;
   assign w_mode = bus.alu_own ? bus.alu_mode : ALU_ADD;

   alu #(.WIDTH(WIDTH)) u_alu (
      .i_in1  (w_in1),
      .i_in2  (w_in2),
      .i_mode (w_mode),
      .o_out  (bus.alu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
      int msb;
      msb = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) msb = i;
      end
      return 2 * (msb + 1) + $countones(b) + 1;
`else
      return 33 + $countones(b);
`endif
   endfunction

   // abort_cyc: cycle in which abort is high (-1 none); poke_cyc: cycle of an extra start with 7x7
   task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                         input int abort_cyc, input int poke_cyc);
      logic [31:0] full;
      sb_t         e;
      bit          seen;
      int          busy_cnt;
      full  = 32'(a) * 32'(b);
      e.res = full[15:0];
      e.ovf = (full[31:16] != 16'h0);
      e.lat = exp_lat(b);
      if (abort_cyc < 0) sb_q.push_back(e);
      @(negedge clk);
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      @(posedge clk);
      seen     = 1'b0;
      busy_cnt = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if (bus.busy) busy_cnt++;
         if (abort_cyc >= 0 && k == abort_cyc + 1) begin
            check("busy_after_abort", 32'(bus.busy), 32'd0);
            check("result_after_abort", 32'(bus.result), 32'(last_res));
            break;
         end
         if (bus.done) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("result", 32'(bus.result), 32'(e.res));
               check("ovf", 32'(bus.ovf), 32'(e.ovf));
               check("done_cycle", 32'(k), 32'(e.lat));
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
               check("alu_in1_in_done", 32'(bus.alu_in1), 32'd0);
               last_res = e.res;
               last_ovf = e.ovf;
            end
            break;
         end
         if (k + 1 == poke_cyc) begin
            bus.start = 1'b1;
            bus.op_a  = 16'd7;
            bus.op_b  = 16'd7;
         end
         if (k + 1 == abort_cyc) bus.abort = 1'b1;
      end
      if (abort_cyc < 0) begin
         if (!seen) check("done_timeout", 32'd0, 32'd1);
         @(negedge clk);
         check("done_one_cycle", 32'(bus.done), 32'd0);
         check("result_held", 32'(bus.result), 32'(last_res));
         check("ovf_held", 32'(bus.ovf), 32'(last_ovf));
      end else begin
         seen = 1'b0;
         repeat (60) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
         end
         check("no_done_after_abort", 32'(seen), 32'd0);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      last_res  = '0;
      last_ovf  = 1'b0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_alu_own", 32'(bus.alu_own), 32'd0);
      check("rst_alu_in", 32'({bus.alu_in1, bus.alu_in2}), 32'd0);
      check("rst_alu_mode", 32'(bus.alu_mode), 32'(ALU_ADD));
      rst_n = 1'b1;

      do_mul(16'd3, 16'd5, -1, -1);
      do_mul(16'h0100, 16'h0100, -1, -1);
      do_mul(16'hFFFF, 16'h0001, -1, -1);
      do_mul(16'h8000, 16'h0002, -1, -1);
      do_mul(16'h8000, 16'h0001, -1, -1);
      do_mul(16'd3, 16'd5, -1, 10);
      do_mul(16'd9, 16'd9, 12, -1);
      do_mul(16'hFFFF, 16'h0000, -1, -1);
      do_mul(16'h0000, 16'hFFFF, -1, -1);
      do_mul(16'd7, 16'h0001, -1, -1);
      do_mul(16'hFFFF, 16'hFFFF, -1, -1);
      for (int i = 0; i < 4; i++) begin
         do_mul(16'($urandom), 16'($urandom_range(0, 255)), -1, -1);
      end

      // asynchronous reset in the middle of 0x1234 * 0x00FF
      @(negedge clk);
      bus.op_a  = 16'h1234;
      bus.op_b  = 16'h00FF;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      check("busy_before_reset", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("areset_busy", 32'(bus.busy), 32'd0);
      check("areset_result", 32'(bus.result), 32'd0);
      check("areset_ovf", 32'(bus.ovf), 32'd0);
      check("areset_alu_in1", 32'(bus.alu_in1), 32'd0);
      check("areset_alu_mode", 32'(bus.alu_mode), 32'(ALU_ADD));
      check("areset_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_res = '0;
      last_ovf = 1'b0;
      do_mul(16'h1234, 16'h00FF, -1, -1);

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
